map_ss_engine: RTL
==================

Name: map_ss_engine

Overview:
- Save-state initiator for mapper cores; drives the mapper save-state port (ss_act, ss_we, ss_addr) and the per-mapper readback ss_rdat.
- Save: sweeps mapper state addresses 0..ADDR_LAST and captures each ss_rdat into an internal 128x8 buffer.
- Load: sweeps the same addresses and writes buffer bytes into the mapper, generating the m2/m3 strobes the mapper latches on.
- Sits between the host/menu side (buffer port and commands) and the mapper bus.

Parameters:
- ADDR_LAST, 127: last state address swept; range 0..127.
- SETUP_CYC, 2: clocks that address/data are held stable before the strobe (min 1).
- PULSE_CYC, 4: clocks of ss_m2 high per write strobe (min 2).

Ports:
- clk  in  1  system clock
- map_rst  in  1  synchronous active-high reset
- cmd_save  in  1  one-clock pulse: start save sweep
- cmd_load  in  1  one-clock pulse: start load sweep
- busy  out  1  sweep in progress
- done  out  1  one-clock pulse when a sweep completes
- buf_addr  in  7  host buffer address
- buf_we  in  1  host buffer write strobe
- buf_wdat  in  8  host buffer write data
- buf_rdat  out  8  host buffer read data, registered, 1-clock latency
- ss_act  out  1  save-state mode to mapper
- ss_we  out  1  save-state write enable to mapper
- ss_addr  out  8  state address; bit 7 is always 0
- ss_wdat  out  8  data to mapper (drives cpu_dat during ss_act)
- ss_m2  out  1  synthetic m2 strobe; mapper latches on the falling edge
- ss_m3  out  1  qualifier for counter/pending writes; equals ss_m2 during load
- ss_rdat  in  8  mapper readback, combinational from ss_addr

Behaviour:
- Reset values:
  - busy=0, done=0, ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, ss_m2=0, ss_m3=0, buf_rdat=0.
  - Buffer RAM is not cleared.
- States: IDLE, SETUP, STROBE, HOLD, FIN.
- IDLE:
  - cmd_save or cmd_load -> SETUP; mode latched, address counter=0.
  - If both are asserted the same clock, save wins.
  - Commands arriving while busy are ignored.
- SETUP:
  - Lasts SETUP_CYC clocks.
  - ss_act=1, ss_addr=counter, ss_wdat=buffer[counter] (buffer pre-read one clock earlier).
  - ss_we=1 in load mode, 0 in save mode.
- STROBE:
  - Lasts PULSE_CYC clocks.
  - Load: ss_m2=ss_m3=1.
  - Save: ss_m2=ss_m3=0; the state still elapses so timing is uniform.
- HOLD:
  - Lasts 1 clock; ss_m2=0, so the falling edge occurs here.
  - Save: buffer[counter] <= ss_rdat.
  - If counter==ADDR_LAST -> FIN; else counter+1 and -> SETUP.
  - ss_addr, ss_wdat and ss_we stay stable through HOLD.
- FIN:
  - 1 clock; ss_act=0, ss_we=0, done=1.
  - Then -> IDLE.
- busy=1 in every state except IDLE.
- Per-address cost is SETUP_CYC+PULSE_CYC+1 clocks; default 7 clocks, so a full sweep is 896 clocks plus 1 FIN clock.
- Addresses are swept strictly ascending. This guarantees irq enable (17) is restored before irq pending (19).
- Host port:
  - buf_rdat <= buffer[buf_addr] every clock.
  - buf_we is honoured only in IDLE and ignored while busy.
  - Engine and host share a single RAM read port; the engine owns it while busy, so buf_rdat is undefined during a sweep.
- Unimplemented mapper addresses return 0xFF on save and are captured as-is.
- map_rst mid-sweep: next clock goes to IDLE with all outputs at reset values and no done pulse. Partially written buffer contents are retained.
- ss_act is never high with ss_m2 rising in the same clock as an ss_addr change. Address/data change only on the SETUP entry clock.

Test Plan:
- Save with stub mapper (ss_rdat = ss_addr ^ 0x5A): after done, buf_rdat for buf_addr 0, 9 and 127 reads 0x5A, 0x53 and 0x25. Exactly 897 clocks of busy, done high 1 clock, ss_m2 never toggles.
- Load: preload buffer[n]=n+1 via host port, pulse cmd_load. The stub sees 128 ss_m2 falling edges with ss_we=1 and (ss_addr, ss_wdat) = (n, n+1) in ascending order. Edge for addr 17 precedes addr 19.
- Simultaneous cmd_save & cmd_load: a save sweep runs (ss_we stays 0 throughout). A cmd_load pulsed at clock 100 of the sweep is ignored and no second sweep follows.
- map_rst asserted at clock 300 of a load: the next clock shows ss_act=0, busy=0, ss_m2=0 and no done. Buffer entries 0..127 are unchanged.
- buf_we with buf_addr=3, data 0xC3 during busy: buffer[3] is not written. The same write in IDLE reads back 0xC3 one clock after addressing.
- ADDR_LAST=10, SETUP_CYC=1, PULSE_CYC=2: the save completes in 11*4+1=45 busy clocks, and ss_addr never exceeds 10.

Source files
------------

// File: rtl/map_ss_engine.sv
// Save-state initiator for mapper cores.
// Save sweeps mapper state addresses 0..ADDR_LAST and captures the mapper
// readback into a 128x8 buffer. Load sweeps the same addresses and replays the
// buffer into the mapper through synthetic m2/m3 write strobes. The host side
// can access the buffer through a registered port while the engine is idle.
module map_ss_engine #(
    parameter int ADDR_LAST = 127,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       cmd_save,
    input  logic       cmd_load,
    output logic       busy,
    output logic       done,
    input  logic [6:0] buf_addr,
    input  logic       buf_we,
    input  logic [7:0] buf_wdat,
    output logic [7:0] buf_rdat,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    output logic       ss_m2,
    output logic       ss_m3,
    input  logic [7:0] ss_rdat
);

    localparam int CW = 8;
    localparam logic [CW-1:0] SETUP_END = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYC - 1);
    localparam logic [6:0]    ADDR_END  = 7'(ADDR_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_FIN
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          start;
    logic [CW-1:0] cyc_cnt;
    logic [6:0]    addr_cnt;
    logic          mode_load;

    logic [7:0]    mem [0:127];
    logic [6:0]    rd_addr;
    logic [7:0]    rd_dat_p1;

    // Next-state decode and mapper-side outputs, all decoded from registers
    // so address/data only move on the clock that enters SETUP.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        ss_act  = 1'b0;
        ss_we   = 1'b0;
        ss_addr = 8'h00;
        ss_wdat = 8'h00;
        ss_m2   = 1'b0;
        ss_m3   = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_save || cmd_load) begin
                    state_n = S_SETUP;
                    start   = 1'b1;
                end
            end
            S_SETUP: begin
                if (cyc_cnt == SETUP_END) state_n = S_STROBE;
            end
            S_STROBE: begin
                if (cyc_cnt == PULSE_END) state_n = S_HOLD;
            end
            S_HOLD: begin
                state_n = (addr_cnt == ADDR_END) ? S_FIN : S_SETUP;
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy = (state != S_IDLE);
        done = (state == S_FIN);
        if (state == S_SETUP || state == S_STROBE || state == S_HOLD) begin
            ss_act  = 1'b1;
            ss_we   = mode_load;
            ss_addr = {1'b0, addr_cnt};
            // rd_dat_p1 holds buffer[addr_cnt] from SETUP entry through HOLD
            ss_wdat = rd_dat_p1;
        end
        if (state == S_STROBE && mode_load) begin
            ss_m2 = 1'b1;
            ss_m3 = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Phase counter, address counter and latched sweep direction.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            cyc_cnt   <= '0;
            addr_cnt  <= '0;
            mode_load <= 1'b0;
        end else begin
            if (start) begin
                addr_cnt  <= '0;
                // save wins when both commands arrive together
                mode_load <= ~cmd_save;
            end else if (state == S_HOLD && state_n == S_SETUP) begin
                addr_cnt <= addr_cnt + 7'd1;
            end

            if (state == S_IDLE || state_n != state) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    // Single read port: host owns it when idle, engine pre-reads the next
    // address one clock ahead of SETUP entry while busy.
    always_comb begin
        rd_addr = addr_cnt;
        if (state == S_IDLE) begin
            rd_addr = start ? 7'd0 : buf_addr;
        end else if (state == S_HOLD) begin
            rd_addr = addr_cnt + 7'd1;
        end
    end

    // Buffer writes: host only while idle, engine capture in HOLD of a save.
    always_ff @(posedge clk) begin
        if (!map_rst) begin
            if (state == S_IDLE && buf_we) begin
                mem[buf_addr] <= buf_wdat;
            end else if (state == S_HOLD && !mode_load) begin
                mem[addr_cnt] <= ss_rdat;
            end
        end
    end

    // Registered buffer read.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            rd_dat_p1 <= 8'h00;
        end else begin
            rd_dat_p1 <= mem[rd_addr];
        end
    end

    assign buf_rdat = rd_dat_p1;

endmodule
